regfile_scoreboard: RTL and testbench

REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

---
 rtl/regfile_scoreboard_if.sv | 29 ++
 rtl/regfile_scoreboard.sv | 75 +++++++
 tb/tb_regfile_scoreboard.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/regfile_scoreboard_if.sv
// Bundles the write, read and issue signals of the register file with its busy scoreboard.
// Handshake: no valid/ready; LE and SE are single-cycle strobes, each taking effect on the rising edge at which it is high.
interface regfile_scoreboard_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [DATA_W-1:0] PW;
  logic [ADDR_W-1:0] RW;
  logic              LE;
  logic [ADDR_W-1:0] RA;
  logic [ADDR_W-1:0] RB;
  logic [DATA_W-1:0] PA;
  logic [DATA_W-1:0] PB;
  logic              SE;
  logic [ADDR_W-1:0] SR;
  logic              BUSY_A;
  logic              BUSY_B;
  logic [ADDR_W:0]   BUSY_CNT;

  modport master (
    output PW, RW, LE, RA, RB, SE, SR,
    input  PA, PB, BUSY_A, BUSY_B, BUSY_CNT
  );

  modport slave (
    input  PW, RW, LE, RA, RB, SE, SR,
    output PA, PB, BUSY_A, BUSY_B, BUSY_CNT
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Two-read/one-write register file with write-to-read bypass and a per-register busy
// scoreboard; an issue marks a destination pending until its write arrives.
module regfile_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter bit ZERO_R0  = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  regfile_scoreboard_if.slave bus
);
  localparam int CNT_W = ADDR_W + 1;

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_d;

  logic wr_ok;
  logic iss_ok;
  logic fwd_a;
  logic fwd_b;
  logic zero_a;
  logic zero_b;

  always_comb begin
    wr_ok  = bus.LE && !(ZERO_R0 && (bus.RW == '0));
    iss_ok = bus.SE && !(ZERO_R0 && (bus.SR == '0));
    fwd_a  = bus.LE && (bus.RW == bus.RA);
    fwd_b  = bus.LE && (bus.RW == bus.RB);
    zero_a = ZERO_R0 && (bus.RA == '0);
    zero_b = ZERO_R0 && (bus.RB == '0);
  end

  // Issue is applied after the write so a same-register collision leaves the new producer pending.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (wr_ok) begin
      regs_d[bus.RW] = bus.PW;
      busy_d[bus.RW] = 1'b0;
    end
    if (iss_ok) begin
      busy_d[bus.SR] = 1'b1;
    end
    cnt_d = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      cnt_d = cnt_d + CNT_W'(busy_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  // A value being written this cycle is forwarded and therefore reported as ready.
  assign bus.PA       = zero_a ? '0 : (fwd_a ? bus.PW : regs_q[bus.RA]);
  assign bus.PB       = zero_b ? '0 : (fwd_b ? bus.PW : regs_q[bus.RB]);
  assign bus.BUSY_A   = busy_q[bus.RA] && !fwd_a;
  assign bus.BUSY_B   = busy_q[bus.RB] && !fwd_b;
  assign bus.BUSY_CNT = cnt_q;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: a 32x32 instance carries most scenarios and a
// 16-bit, 8-register instance joins the mid-operation reset scenario.
module tb_regfile_scoreboard;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_scoreboard_if #(.DATA_W(32), .ADDR_W(5)) bus ();
  regfile_scoreboard_if #(.DATA_W(16), .ADDR_W(3)) bus2 ();

  regfile_scoreboard #(.DATA_W(32), .NUM_REGS(32), .ADDR_W(5), .ZERO_R0(1'b1)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  regfile_scoreboard #(.DATA_W(16), .NUM_REGS(8), .ADDR_W(3), .ZERO_R0(1'b1)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.LE = 1'b0;  bus.SE = 1'b0;
    bus2.LE = 1'b0; bus2.SE = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.PW = 32'h5555_AAAA; bus.RW = 5'd5; bus.LE = 1'b1; bus.SE = 1'b1; bus.SR = 5'd5;
    bus.RA = 5'd5; bus.RB = 5'd1;
    bus2.PW = 16'h0; bus2.RW = 3'd0; bus2.LE = 1'b0; bus2.SE = 1'b0; bus2.SR = 3'd0;
    bus2.RA = 3'd0; bus2.RB = 3'd0;
    tick();
    tick();
    reset = 1'b0;
    idle();
    #1;
    checks++; if (bus.PA !== 32'h0) begin errors++; $display("FAIL reset_pa got %h exp %h", bus.PA, 32'h0); end
    checks++; if (bus.PB !== 32'h0) begin errors++; $display("FAIL reset_pb got %h exp %h", bus.PB, 32'h0); end
    checks++; if (bus.BUSY_A !== 1'b0) begin errors++; $display("FAIL reset_busy_a got %b exp 0", bus.BUSY_A); end
    checks++; if (bus.BUSY_CNT !== 6'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", bus.BUSY_CNT); end
  endtask

  task automatic test_write();
    bus.LE = 1'b1; bus.RW = 5'd5; bus.PW = 32'hDEAD_BEEF;
    tick();
    idle();
    bus.RA = 5'd5; bus.RB = 5'd0;
    #1;
    checks++; if (bus.PA !== 32'hDEAD_BEEF) begin errors++; $display("FAIL write_pa got %h exp %h", bus.PA, 32'hDEAD_BEEF); end
    checks++; if (bus.PB !== 32'h0) begin errors++; $display("FAIL write_pb got %h exp %h", bus.PB, 32'h0); end
  endtask

  task automatic test_bypass();
    bus.LE = 1'b1; bus.RW = 5'd7; bus.PW = 32'h0000_00A5;
    tick();
    idle();
    bus.RA = 5'd7; bus.RB = 5'd7;
    #1;
    checks++; if (bus.PA !== 32'h0000_00A5) begin errors++; $display("FAIL bypass_pre got %h exp %h", bus.PA, 32'hA5); end
    bus.LE = 1'b1; bus.RW = 5'd7; bus.PW = 32'h1234_5678; bus.RB = 5'd5;
    #1;
    checks++; if (bus.PA !== 32'h1234_5678) begin errors++; $display("FAIL bypass_same_cycle got %h exp %h", bus.PA, 32'h1234_5678); end
    checks++; if (bus.PB !== 32'hDEAD_BEEF) begin errors++; $display("FAIL bypass_other_port got %h exp %h", bus.PB, 32'hDEAD_BEEF); end
    tick();
    idle();
    #1;
    checks++; if (bus.PA !== 32'h1234_5678) begin errors++; $display("FAIL bypass_stored got %h exp %h", bus.PA, 32'h1234_5678); end
  endtask

  task automatic test_r0();
    bus.LE = 1'b1; bus.RW = 5'd0; bus.PW = 32'hFFFF_FFFF; bus.RA = 5'd0;
    #1;
    checks++; if (bus.PA !== 32'h0) begin errors++; $display("FAIL r0_bypass got %h exp %h", bus.PA, 32'h0); end
    tick();
    idle();
    bus.SE = 1'b1; bus.SR = 5'd0;
    tick();
    idle();
    #1;
    checks++; if (bus.PA !== 32'h0) begin errors++; $display("FAIL r0_read got %h exp %h", bus.PA, 32'h0); end
    checks++; if (bus.BUSY_A !== 1'b0) begin errors++; $display("FAIL r0_busy got %b exp 0", bus.BUSY_A); end
    checks++; if (bus.BUSY_CNT !== 6'd0) begin errors++; $display("FAIL r0_cnt got %0d exp 0", bus.BUSY_CNT); end
  endtask

  task automatic test_scoreboard();
    logic [4:0] srs [3];
    srs[0] = 5'd3; srs[1] = 5'd4; srs[2] = 5'd9;
    for (int i = 0; i < 3; i++) begin
      bus.SE = 1'b1; bus.SR = srs[i];
      tick();
    end
    idle();
    bus.RA = 5'd3; bus.RB = 5'd9;
    #1;
    checks++; if (bus.BUSY_CNT !== 6'd3) begin errors++; $display("FAIL sb_cnt3 got %0d exp 3", bus.BUSY_CNT); end
    checks++; if (bus.BUSY_A !== 1'b1) begin errors++; $display("FAIL sb_busy_a3 got %b exp 1", bus.BUSY_A); end
    checks++; if (bus.BUSY_B !== 1'b1) begin errors++; $display("FAIL sb_busy_b9 got %b exp 1", bus.BUSY_B); end
    bus.LE = 1'b1; bus.RW = 5'd4; bus.PW = 32'h0000_0044; bus.RA = 5'd4;
    #1;
    checks++; if (bus.BUSY_A !== 1'b0) begin errors++; $display("FAIL sb_fwd_ready got %b exp 0", bus.BUSY_A); end
    checks++; if (bus.PA !== 32'h44) begin errors++; $display("FAIL sb_fwd_data got %h exp %h", bus.PA, 32'h44); end
    tick();
    idle();
    #1;
    checks++; if (bus.BUSY_CNT !== 6'd2) begin errors++; $display("FAIL sb_cnt2 got %0d exp 2", bus.BUSY_CNT); end
    checks++; if (bus.BUSY_A !== 1'b0) begin errors++; $display("FAIL sb_cleared got %b exp 0", bus.BUSY_A); end
  endtask

  task automatic test_collision();
    // busy now {3,9}; add 6
    bus.SE = 1'b1; bus.SR = 5'd6;
    tick();
    bus.SE = 1'b1; bus.SR = 5'd6; bus.LE = 1'b1; bus.RW = 5'd6; bus.PW = 32'h0000_0066;
    tick();
    idle();
    bus.RA = 5'd6;
    #1;
    checks++; if (bus.BUSY_A !== 1'b1) begin errors++; $display("FAIL coll_busy got %b exp 1", bus.BUSY_A); end
    checks++; if (bus.BUSY_CNT !== 6'd3) begin errors++; $display("FAIL coll_cnt got %0d exp 3", bus.BUSY_CNT); end
    checks++; if (bus.PA !== 32'h66) begin errors++; $display("FAIL coll_data got %h exp %h", bus.PA, 32'h66); end
    // issue to 10 while retiring 3 on the same edge; then re-issue busy 6 and write idle 12
    bus.SE = 1'b1; bus.SR = 5'd10; bus.LE = 1'b1; bus.RW = 5'd3; bus.PW = 32'h0000_0033;
    tick();
    bus.SE = 1'b1; bus.SR = 5'd6; bus.LE = 1'b1; bus.RW = 5'd12; bus.PW = 32'h0000_0C0C;
    tick();
    idle();
    bus.RA = 5'd3; bus.RB = 5'd10;
    #1;
    checks++; if (bus.BUSY_A !== 1'b0) begin errors++; $display("FAIL split_busy3 got %b exp 0", bus.BUSY_A); end
    checks++; if (bus.BUSY_B !== 1'b1) begin errors++; $display("FAIL split_busy10 got %b exp 1", bus.BUSY_B); end
    checks++; if (bus.PA !== 32'h33) begin errors++; $display("FAIL split_data3 got %h exp %h", bus.PA, 32'h33); end
    checks++; if (bus.BUSY_CNT !== 6'd3) begin errors++; $display("FAIL split_cnt got %0d exp 3", bus.BUSY_CNT); end
    bus.RA = 5'd12; bus.RB = 5'd6;
    #1;
    checks++; if (bus.PA !== 32'h0C0C) begin errors++; $display("FAIL idle_write_data got %h exp %h", bus.PA, 32'h0C0C); end
    checks++; if (bus.BUSY_A !== 1'b0) begin errors++; $display("FAIL idle_write_busy got %b exp 0", bus.BUSY_A); end
    checks++; if (bus.BUSY_B !== 1'b1) begin errors++; $display("FAIL reissue_busy got %b exp 1", bus.BUSY_B); end
  endtask

  task automatic test_mid_reset();
    // main: busy {9,6,10} plus 11, 13 -> 5 busy
    bus.SE = 1'b1; bus.SR = 5'd11;
    tick();
    bus.SR = 5'd13;
    tick();
    for (int i = 1; i <= 5; i++) begin
      bus2.SE = 1'b1; bus2.SR = 3'(i); bus2.LE = 1'b1; bus2.RW = 3'(i); bus2.PW = 16'h1000 + 16'(i);
      tick();
    end
    idle();
    bus.RA = 5'd5; bus2.RA = 3'd3;
    #1;
    checks++; if (bus.BUSY_CNT !== 6'd5) begin errors++; $display("FAIL mr_pre_cnt got %0d exp 5", bus.BUSY_CNT); end
    checks++; if (bus2.BUSY_CNT !== 4'd5) begin errors++; $display("FAIL mr_pre_cnt2 got %0d exp 5", bus2.BUSY_CNT); end
    checks++; if (bus2.PA !== 16'h1003) begin errors++; $display("FAIL mr_pre_data2 got %h exp %h", bus2.PA, 16'h1003); end
    reset = 1'b1;
    bus.SE = 1'b1; bus.SR = 5'd14; bus.LE = 1'b1; bus.RW = 5'd15; bus.PW = 32'h0F0F_0F0F;
    bus2.SE = 1'b1; bus2.SR = 3'd6; bus2.LE = 1'b1; bus2.RW = 3'd7; bus2.PW = 16'h7777;
    #1;
    checks++; if (bus.BUSY_CNT !== 6'd5) begin errors++; $display("FAIL mr_no_async_cnt got %0d exp 5", bus.BUSY_CNT); end
    checks++; if (bus.PA !== 32'hDEAD_BEEF) begin errors++; $display("FAIL mr_no_async_data got %h exp %h", bus.PA, 32'hDEAD_BEEF); end
    tick();
    reset = 1'b0;
    idle();
    #1;
    checks++; if (bus.BUSY_CNT !== 6'd0) begin errors++; $display("FAIL mr_cnt got %0d exp 0", bus.BUSY_CNT); end
    checks++; if (bus2.BUSY_CNT !== 4'd0) begin errors++; $display("FAIL mr_cnt2 got %0d exp 0", bus2.BUSY_CNT); end
    for (int r = 0; r < 32; r++) begin
      bus.RA = 5'(r); bus.RB = 5'(31 - r);
      #1;
      checks++; if (bus.PA !== 32'h0) begin errors++; $display("FAIL mr_reg%0d got %h exp %h", r, bus.PA, 32'h0); end
      checks++; if (bus.BUSY_A !== 1'b0 || bus.BUSY_B !== 1'b0) begin errors++; $display("FAIL mr_busy%0d got %b%b exp 00", r, bus.BUSY_A, bus.BUSY_B); end
    end
    for (int r = 0; r < 8; r++) begin
      bus2.RA = 3'(r); bus2.RB = 3'(7 - r);
      #1;
      checks++; if (bus2.PA !== 16'h0 || bus2.PB !== 16'h0) begin errors++; $display("FAIL mr2_reg%0d got %h/%h exp 0", r, bus2.PA, bus2.PB); end
      checks++; if (bus2.BUSY_A !== 1'b0 || bus2.BUSY_B !== 1'b0) begin errors++; $display("FAIL mr2_busy%0d got %b%b exp 00", r, bus2.BUSY_A, bus2.BUSY_B); end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_bypass();
    test_r0();
    test_scoreboard();
    test_collision();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
